// File: rtl/bcd2binary_sequential.sv
// Sequential BCD-to-binary converter (reverse double-dabble: shift right, then
// subtract 3 from every BCD nibble that reached 8 or more).
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - conversion request, accepted only in IDLE or DONE
//   bcd_in  - packed BCD operand (nibble 0 = ones digit), captured on accept
//   busy    - high while a conversion (or error report) is in flight
//   done    - one-cycle pulse; bin_out/err valid from this cycle on
//   err     - operand had a nibble > 9; held until the next accepted start
//   bin_out - converted value; held until the next conversion completes
module bcd2binary_sequential #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BW     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BW-1:0]         bin_out
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned WORK_W = BCD_W + BW;
  localparam int unsigned CNT_W  = $clog2(BW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ERR,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [WORK_W-1:0]   work_q;
  logic [WORK_W-1:0]   work_shr;
  logic [WORK_W-1:0]   work_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [BW-1:0]       bin_out_q;
  logic                bad_digit;

  // One iteration: shift {bcd, bin} right, then fix each BCD nibble in parallel.
  // Nibbles >= 8 never borrow, so the corrections are independent.
  always_comb begin
    work_shr = work_q >> 1;
    work_d   = work_shr;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (work_shr[BW + 4*d +: 4] >= 4'd8) begin
        work_d[BW + 4*d +: 4] = work_shr[BW + 4*d +: 4] - 4'd3;
      end
    end
  end

  // Any nibble above 9 makes the operand invalid.
  always_comb begin
    bad_digit = 1'b0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      bin_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            work_q  <= {bcd_in, BW'(0)};
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= bad_digit ? S_ERR : S_SHIFT;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Last iteration: publish the result on this edge.
          if (cnt_q == CNT_W'(BW - 1)) begin
            bin_out_q <= work_d[BW-1:0];
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_DONE;
          end
        end
        S_ERR: begin
          bin_out_q <= '0;
          err_q     <= 1'b1;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_out_q;

endmodule

// File: doc/bcd2binary_sequential.md
Name: bcd2binary_sequential

Overview:
Sequential BCD-to-binary converter using reverse double-dabble (shift-right, subtract-3), the inverse of the binary2bcd family. Accepts a packed BCD word with a start/done handshake and produces the binary value after a fixed number of clocks. Sits between the front-panel/keypad BCD entry logic and the binary datapath. Also serves as the round-trip checker in the binary2bcd test harness.

Parameters:
DIGITS, 4, number of BCD digits in bcd_in (nibble 0 = ones digit, LSBs)
BW, 16, binary result width; must satisfy 2^BW > 10^DIGITS - 1 (16 for 4 digits)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk; accepted only in IDLE or DONE
bcd_in  input  4*DIGITS  packed BCD operand; captured on the accepting edge only
busy  output  1  high while state is SHIFT or ERR
done  output  1  one-cycle pulse; bin_out/err valid in that cycle and held afterwards
err  output  1  set when the captured operand had any nibble > 9; held until next accepted start
bin_out  output  BW  converted value; held until the next conversion completes

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, err=0, bin_out=0; shift register and counter cleared. Takes effect immediately, including mid-conversion. The aborted conversion produces no done.
- Working register: {bcd_r[4*DIGITS-1:0], bin_r[BW-1:0]}. Iteration counter width is ceil(log2(BW+1)).
- States:
  - IDLE: wait for start.
  - SHIFT: one iteration per clock.
  - ERR: one cycle.
  - DONE: one cycle.
- Accept (IDLE or DONE, start=1):
  - Load bcd_r=bcd_in, bin_r=0, count=0; clear err.
  - If any nibble of bcd_in > 9, go to ERR. Otherwise go to SHIFT.
- SHIFT iteration, each clock:
  - Shift the whole register right by 1; the bcd_r LSB enters the bin_r MSB.
  - Then, for each digit nibble of the shifted bcd_r, if the nibble >= 8, subtract 3. All digits are corrected in parallel, the same cycle.
  - count increments.
  - On the edge performing iteration BW: bin_out <= final bin_r, done <= 1, state -> DONE.
- ERR: on the next edge bin_out <= 0, err <= 1, done <= 1, state -> DONE.
- DONE: done high for exactly this cycle.
  - start=1 here is accepted as in IDLE (back-to-back, no bubble).
  - Otherwise state -> IDLE.
- Latency:
  - Valid operand: done is high in the cycle following the BW-th edge after the accepting edge (BW clocks; 16 for defaults).
  - Invalid operand: done high 1 clock after the accepting edge.
- start while busy: ignored. bcd_in is not re-sampled and the in-flight result is unaffected.
- bin_out and err change only on the edge that raises done, or on reset.
- Arithmetic: no overflow is possible given the BW constraint. Subtract-3 is applied only to nibbles >= 8, so there is no borrow between digits.
- busy is combinational from state, or registered with identical timing. done is registered.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, no start -> busy=0, done=0, err=0, bin_out=0 indefinitely.
- Single conversions: bcd_in=16'h1234, start 1 cycle -> done 16 clocks later, bin_out=16'h04D2, err=0. 16'h9999 -> 16'h270F. 16'h0000 -> 16'h0000. 16'h0001 -> 16'h0001.
- Invalid digit: bcd_in=16'h12A4 -> done 1 clock after acceptance, err=1, bin_out=0. A following valid start with 16'h0042 -> err cleared at acceptance, bin_out=16'h002A.
- Busy protection and back-to-back:
  - Start 16'h0500; after 5 clocks assert start with 16'h0999 -> result 16'h01F4, no second done.
  - Start asserted in the done cycle with 16'h0777 -> accepted; next done 16 clocks later with 16'h0309.
- Reset mid-operation: rst_n low during iteration 8 -> outputs zero asynchronously, no done pulse. After release, a new start converts correctly.
- Exhaustive round-trip: for n=0..9999, feed binary2bcdBehavioral(n) into the block -> bin_out==n, err=0 for every n. Cycle count between start and done is always 16.
